cdc_handshake_tx: RTL and testbench
===================================

Name: cdc_handshake_tx

Overview:
- Source-domain end of a two-phase (toggle) req/ack bus-crossing handshake.
- Accepts a WIDTH-bit word through a valid/ready interface and holds it stable on xfer_data.
- Toggles xfer_req to announce the word, then waits for the destination's xfer_ack toggle, synchronized locally, before accepting the next word.
- Adds a watchdog that flags a lost acknowledge.

Parameters:
- WIDTH, 8, data word width in bits.
- SYNC_LENGTH, 2, flop stages synchronizing xfer_ack; minimum 2.
- TIMEOUT, 1024, clk cycles in WAIT_ACK before timeout_err sets; 0 disables the watchdog.

Ports:
- clk  input  1  source-domain clock; all logic rising-edge.
- rst_n  input  1  asynchronous active-low reset, synchronous deassertion provided externally.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  WIDTH  upstream word.
- xfer_data  output  WIDTH  held word to destination domain; registered.
- xfer_req  output  1  request toggle level; registered, glitch-free.
- xfer_ack  input  1  acknowledge toggle from destination domain; asynchronous to clk.
- busy  output  1  high while a transfer is outstanding.
- timeout_err  output  1  sticky watchdog flag.
- err_clr  input  1  single-cycle clear of timeout_err.

Behaviour:
- One clock domain, clk; reset is asynchronous and active-low on rst_n.
- Reset values:
  - state=IDLE, xfer_req=0, xfer_data=0, ack synchronizer stages=0, timeout counter=0, timeout_err=0, busy=0.
- ack_s is the SYNC_LENGTH-stage synchronized xfer_ack. Synchronizer flops carry ASYNC_REG.
- in_ready = (state==IDLE) && (ack_s==xfer_req). It is combinational from registers only, with no path from in_valid.
- IDLE:
  - On in_valid && in_ready at edge N: xfer_data<=in_data, xfer_req<=~xfer_req, state<=WAIT_ACK, counter<=0.
  - From edge N, in_ready=0 and busy=1.
  - xfer_data changes only on this edge. It changes in the same cycle as the req toggle, so it is stable for the whole time the destination samples it.
- WAIT_ACK:
  - Leaves when ack_s==xfer_req: state<=IDLE, busy<=0. in_ready rises the cycle after ack_s matches.
  - in_valid is ignored; in_data is not sampled.
- Minimum loop: accept, then 1 cycle to req, then destination latency, then SYNC_LENGTH cycles to ack_s, then 1 cycle to IDLE.
- Watchdog (TIMEOUT>0):
  - Counter increments each WAIT_ACK cycle and saturates at TIMEOUT.
  - When it reaches TIMEOUT, timeout_err<=1.
  - The state remains WAIT_ACK; no abort, because a two-phase toggle cannot be safely retracted.
  - A late ack still completes the transfer normally; timeout_err stays set.
- err_clr clears timeout_err next edge. If err_clr and the set condition occur in the same cycle, set wins.
- Counter resets to 0 on every accept.
- Ack mismatch in IDLE (destination reset or glitch): in_ready is held low until ack_s equals xfer_req. No spurious transfer is issued.
- Extra ack toggle while in WAIT_ACK: it is consumed as the acknowledge. This is a protocol violation by the destination; the block takes no further action.
- Reset mid-transfer: everything returns to reset values immediately. The destination is required to be reset in the same reset event so that its ack toggle returns to 0.

Decomposition:
- Package cdc_hs_pkg:
  - state encoding localparams ST_IDLE=1'b0, ST_WAIT_ACK=1'b1.
  - counter width function clog2(TIMEOUT+1).
  - SYNC_LENGTH minimum-check constant.
- Sub-module sync_bit_arst: single-bit SYNC_LENGTH-stage synchronizer with async active-low reset and ASYNC_REG attribute. It is reused by the destination-side receiver for xfer_req.

Test Plan:
- Single word: after reset, in_valid=1, in_data=8'hA5 at edge 0 -> edge 1: xfer_data=A5, xfer_req=1, in_ready=0, busy=1. Bench drives xfer_ack=1 at edge 5 -> ack_s=1 at edge 7, in_ready=1 at edge 8.
- Back-to-back: stream 8'h01..8'h04 with in_valid held high and model ack delay 3 -> exactly four req toggles (xfer_req ends 0), xfer_data sequence 01,02,03,04, no word dropped or duplicated, in_data ignored while busy.
- Timeout: TIMEOUT=16, never toggle ack -> timeout_err=1 exactly 16 WAIT_ACK cycles after accept; ack toggle at cycle 40 -> returns to IDLE, timeout_err still 1. err_clr pulse -> 0 next edge.
- Clear/set collision: assert err_clr on the cycle the counter hits TIMEOUT -> timeout_err=1.
- Reset mid-transfer: rst_n low asynchronously during WAIT_ACK with xfer_req=1 -> xfer_req, busy, xfer_data drop to 0 without a clock edge. After release with ack=0 -> in_ready=1.
- Ack mismatch in IDLE: hold xfer_ack=1 after reset -> in_ready stays 0 and no xfer_req toggle despite in_valid=1; return ack to 0 -> in_ready=1 after SYNC_LENGTH+0..1 cycles.

Source files
------------

// File: rtl/cdc_handshake_tx_pkg.sv
// Shared constants and helpers for the toggle req/ack source-side transmitter.
package cdc_hs_pkg;

    // Transmitter state encoding, kept as plain constants for legacy tools.
    localparam logic [0:0] ST_IDLE     = 1'b0;
    localparam logic [0:0] ST_WAIT_ACK = 1'b1;

    // Fewer than two flops cannot settle a metastable ack sample.
    localparam int SYNC_LENGTH_MIN = 2;

    // Width of a counter that must hold values 0..timeout (at least 1 bit).
    function automatic int cnt_width(input int timeout);
        int w;
        w = $clog2(timeout + 1);
        return (w < 1) ? 1 : w;
    endfunction

    // Synchronizer depth clamped to the safe minimum.
    function automatic int sync_stages(input int requested);
        return (requested < SYNC_LENGTH_MIN) ? SYNC_LENGTH_MIN : requested;
    endfunction

endpackage

// File: rtl/cdc_handshake_tx_if.sv
// Upstream valid/ready port, crossing bus and watchdog signals of the transmitter.
interface cdc_handshake_tx_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic [WIDTH-1:0] xfer_data;
    logic             xfer_req;
    logic             xfer_ack;
    logic             busy;
    logic             timeout_err;
    logic             err_clr;

    // Transmitter side: owns the held word, the req toggle and the status flags.
    modport master (
        input  in_valid,
        input  in_data,
        input  xfer_ack,
        input  err_clr,
        output in_ready,
        output xfer_data,
        output xfer_req,
        output busy,
        output timeout_err
    );

    // Environment side: upstream producer plus destination acknowledge.
    modport slave (
        output in_valid,
        output in_data,
        output xfer_ack,
        output err_clr,
        input  in_ready,
        input  xfer_data,
        input  xfer_req,
        input  busy,
        input  timeout_err
    );
endinterface

// File: rtl/cdc_handshake_tx_sync_bit_arst.sv
// Single-bit multi-flop synchronizer with asynchronous active-low reset.
// Also used by the destination-side receiver to bring xfer_req into its domain.
module sync_bit_arst
    import cdc_hs_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);
    localparam int N = sync_stages(STAGES);

    (* ASYNC_REG = "TRUE" *) logic [N-1:0] r_sync;

    // Shift the asynchronous input through the chain; the last flop is the clean copy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[N-2:0], i_d};
        end
    end

    assign o_q = r_sync[N-1];
endmodule

// File: rtl/cdc_handshake_tx.sv
// Source-domain end of a two-phase (toggle) req/ack crossing.
// A word is accepted through valid/ready, held on xfer_data, announced by
// toggling xfer_req, and the next word is refused until the synchronized ack
// toggle matches req again. A watchdog flags an acknowledge that never arrives.
module cdc_handshake_tx
    import cdc_hs_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int SYNC_LENGTH = 2,
    parameter int TIMEOUT     = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    cdc_handshake_tx_if.master bus
);
    localparam int CNT_W = cnt_width(TIMEOUT);

    logic [0:0]       r_state;
    logic             r_req;
    logic [WIDTH-1:0] r_data;
    logic             r_busy;
    logic             r_err;

    logic w_ack_s;
    logic w_ack_match;
    logic w_in_ready;
    logic w_accept;
    logic w_done;
    logic w_set;

    sync_bit_arst #(
        .STAGES (SYNC_LENGTH)
    ) u_ack_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .i_d   (bus.xfer_ack),
        .o_q   (w_ack_s)
    );

    // Ready depends on registers only; a stale ack (destination reset or glitch)
    // keeps ready low so no transfer is launched against a mismatched toggle.
    assign w_ack_match = (w_ack_s == r_req);
    assign w_in_ready  = (r_state == ST_IDLE) && w_ack_match;
    assign w_accept    = bus.in_valid && w_in_ready;
    assign w_done      = (r_state == ST_WAIT_ACK) && w_ack_match;

    // Handshake FSM: data and req update on the same edge so the word is
    // already stable when the destination first sees the toggle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_req   <= 1'b0;
            r_data  <= '0;
            r_busy  <= 1'b0;
        end else if (w_accept) begin
            r_data  <= bus.in_data;
            r_req   <= ~r_req;
            r_state <= ST_WAIT_ACK;
            r_busy  <= 1'b1;
        end else if (w_done) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
        end
    end

    generate
        if (TIMEOUT > 0) begin : g_wdog
            localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);
            localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

            logic [CNT_W-1:0] r_cnt;

            // Count WAIT_ACK cycles since the accept, saturating at the limit.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_cnt <= '0;
                end else if (w_accept) begin
                    r_cnt <= '0;
                end else if ((r_state == ST_WAIT_ACK) && (r_cnt != CNT_MAX)) begin
                    r_cnt <= r_cnt + CNT_W'(1);
                end
            end

            // Fires once, on the edge where the count reaches the limit.
            assign w_set = (r_state == ST_WAIT_ACK) && (r_cnt == CNT_LAST);
        end else begin : g_no_wdog
            assign w_set = 1'b0;
        end
    endgenerate

    // Sticky error: the state is never aborted since a toggle cannot be
    // retracted; a set on the same edge as a clear takes priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err <= 1'b0;
        end else if (w_set) begin
            r_err <= 1'b1;
        end else if (bus.err_clr) begin
            r_err <= 1'b0;
        end
    end

    assign bus.in_ready    = w_in_ready;
    assign bus.xfer_data   = r_data;
    assign bus.xfer_req    = r_req;
    assign bus.busy        = r_busy;
    assign bus.timeout_err = r_err;
endmodule

// File: tb/tb_cdc_handshake_tx.sv
// Directed bench for the toggle-handshake transmitter: single word, streaming,
// watchdog, clear/set collision, async reset mid-transfer, stale ack in IDLE.
module tb_cdc_handshake_tx;
    localparam int WIDTH       = 8;
    localparam int SYNC_LENGTH = 2;
    localparam int TIMEOUT     = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    int   n_total = 0;
    int   n_bad = 0;
    int   n_toggle = 0;
    logic last_req = 1'b0;

    always #5 clk = ~clk;

    cdc_handshake_tx_if #(.WIDTH(WIDTH)) bus ();

    cdc_handshake_tx #(
        .WIDTH       (WIDTH),
        .SYNC_LENGTH (SYNC_LENGTH),
        .TIMEOUT     (TIMEOUT)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Count req toggles, sampled mid-cycle away from the active edge.
    always @(negedge clk) begin
        last_req <= bus.xfer_req;
        if (bus.xfer_req !== last_req) n_toggle <= n_toggle + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(input int max_cyc, output int n);
        n = 0;
        while (!bus.in_ready && n < max_cyc) begin
            tick();
            n++;
        end
    endtask

    task automatic do_reset();
        rst_n        = 1'b0;
        bus.xfer_ack = 1'b0;
        bus.in_valid = 1'b0;
        bus.err_clr  = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        int n;
        int snap;

        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.xfer_ack = 1'b0;
        bus.err_clr  = 1'b0;
        rst_n        = 1'b0;

        // Reset values, before any clock edge.
        #1;
        check_val("rst_ready", bus.in_ready, 1);
        check_val("rst_req", bus.xfer_req, 0);
        check_val("rst_busy", bus.busy, 0);
        check_val("rst_data", bus.xfer_data, 0);
        check_val("rst_err", bus.timeout_err, 0);
        #12;
        rst_n = 1'b1;
        tick();

        // Single word: driven just after edge 0, accepted at edge 1.
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hA5;
        tick();
        check_val("sw_data", bus.xfer_data, 32'hA5);
        check_val("sw_req", bus.xfer_req, 1);
        check_val("sw_ready", bus.in_ready, 0);
        check_val("sw_busy", bus.busy, 1);
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        repeat (4) tick();
        bus.xfer_ack = 1'b1;                 // after edge 5
        tick();                              // edge 6
        check_val("sw_ready_e6", bus.in_ready, 0);
        tick();                              // edge 7: ack_s=1, still WAIT_ACK
        check_val("sw_ready_e7", bus.in_ready, 0);
        check_val("sw_busy_e7", bus.busy, 1);
        tick();                              // edge 8: back in IDLE
        check_val("sw_ready_e8", bus.in_ready, 1);
        check_val("sw_busy_e8", bus.busy, 0);
        check_val("sw_hold", bus.xfer_data, 32'hA5);
        $display("single word A5 acknowledged");

        // Back-to-back stream 01..04, ack answered 3 cycles after each toggle.
        do_reset();
        snap = n_toggle;
        bus.in_valid = 1'b1;
        for (int w = 1; w <= 4; w++) begin
            bus.in_data = 8'(w);
            check_val("b2b_rdy", bus.in_ready, 1);
            tick();
            check_val("b2b_data", bus.xfer_data, w);
            check_val("b2b_req", bus.xfer_req, w % 2);
            bus.in_data = 8'hE0 | 8'(w);     // must be ignored while busy
            repeat (3) tick();
            bus.xfer_ack = bus.xfer_req;
            wait_ready(10, n);
            check_val("b2b_hold", bus.xfer_data, w);
            check_val("b2b_done", bus.in_ready, 1);
            $display("word %0d: data=%02h req=%b ready after %0d", w, bus.xfer_data, bus.xfer_req, n);
        end
        bus.in_valid = 1'b0;
        tick();
        check_val("b2b_req_end", bus.xfer_req, 0);
        check_val("b2b_toggles", n_toggle - snap, 4);

        // Watchdog: no ack; error appears exactly 16 WAIT_ACK cycles after accept.
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h3C;
        tick();                              // accept edge N
        bus.in_valid = 1'b0;
        repeat (15) tick();                  // N+15
        check_val("to_err_n15", bus.timeout_err, 0);
        tick();                              // N+16
        check_val("to_err_n16", bus.timeout_err, 1);
        check_val("to_busy", bus.busy, 1);
        repeat (24) tick();                  // N+40
        bus.xfer_ack = ~bus.xfer_ack;
        wait_ready(10, n);
        check_val("to_late_rdy", bus.in_ready, 1);
        check_val("to_late_busy", bus.busy, 0);
        check_val("to_sticky", bus.timeout_err, 1);
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        check_val("to_clr", bus.timeout_err, 0);
        $display("timeout transfer 3C completed late");

        // Clear and set on the same edge: set wins.
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h77;
        tick();                              // accept edge N
        bus.in_valid = 1'b0;
        check_val("col_req", bus.xfer_req, 0);
        repeat (15) tick();                  // N+15
        check_val("col_err_pre", bus.timeout_err, 0);
        bus.err_clr = 1'b1;
        tick();                              // N+16: set and clear together
        bus.err_clr = 1'b0;
        check_val("col_err", bus.timeout_err, 1);
        bus.xfer_ack = 1'b0;
        wait_ready(10, n);
        check_val("col_rdy", bus.in_ready, 1);

        // Asynchronous reset in WAIT_ACK with req=1.
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h5A;
        tick();
        bus.in_valid = 1'b0;
        check_val("ar_req_pre", bus.xfer_req, 1);
        check_val("ar_busy_pre", bus.busy, 1);
        #3;
        rst_n        = 1'b0;
        bus.xfer_ack = 1'b0;
        #1;
        check_val("ar_req", bus.xfer_req, 0);
        check_val("ar_busy", bus.busy, 0);
        check_val("ar_data", bus.xfer_data, 0);
        check_val("ar_err", bus.timeout_err, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check_val("ar_rdy", bus.in_ready, 1);
        $display("async reset during transfer 5A");

        // Stale ack in IDLE blocks the upstream port and launches nothing.
        bus.xfer_ack = 1'b1;
        repeat (3) tick();
        bus.in_valid = 1'b1;
        bus.in_data  = 8'h99;
        for (int k = 0; k < 4; k++) begin
            check_val("mm_rdy", bus.in_ready, 0);
            check_val("mm_req", bus.xfer_req, 0);
            tick();
        end
        bus.in_valid = 1'b0;
        bus.xfer_ack = 1'b0;
        wait_ready(8, n);
        check_val("mm_rdy_back", bus.in_ready, 1);
        check_val("mm_latency", (n >= SYNC_LENGTH && n <= SYNC_LENGTH + 1), 1);
        check_val("mm_req_end", bus.xfer_req, 0);
        check_val("mm_busy", bus.busy, 0);
        $display("stale ack released after %0d cycles", n);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
